// File: rtl/rv_pkg.sv
// Shared RV32 decode constants and fetch-stage state encoding.
package rv_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {instruction, pc} pairs; flush empties it.
module fetch_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, memory request channel, response queue and redirect flush.
module fetch_unit
    import rv_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH  = 32,
    parameter int unsigned            INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
    parameter int unsigned            QDEPTH      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [ADDR_WIDTH-1:0]  imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirect_target,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic [6:0]             opcode,
    output logic [2:0]             funct3,
    output logic [6:0]             funct7
);

    localparam int unsigned   CW   = $clog2(QDEPTH + 1);
    localparam logic [CW:0]   QLIM = (CW + 1)'(QDEPTH);

    fetch_state_e state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]         outstanding_q, outstanding_d;
    logic [CW-1:0]         discard_q, discard_d;

    logic                  issue_en, req_fire, rsp_fire, push, pop, head_valid;
    logic [CW-1:0]         q_count;
    logic [CW:0]           occ_sum;
    logic [INSTR_WIDTH+ADDR_WIDTH-1:0] head;
    logic [ADDR_WIDTH-1:0] target_aligned;

    assign target_aligned = redirect_target & ~ADDR_WIDTH'(3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= BOOT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (redirect && discard_d != '0) state_d = FLUSH;
            FLUSH:   if (!redirect && discard_d == '0) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        issue_en = (state_q != BOOT);
    end

    assign occ_sum        = {1'b0, q_count} + {1'b0, outstanding_q};
    assign imem_req_valid = issue_en & ~redirect & (occ_sum < QLIM);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;
    // Responses with nothing outstanding are protocol errors and are ignored.
    assign rsp_fire       = imem_rsp_valid & (outstanding_q != '0);
    assign push           = rsp_fire & (discard_q == '0) & ~redirect;
    assign head_valid     = (q_count != '0);
    assign pop            = head_valid & instr_ready;

    // rsp_pc tracks the PC of the next kept response; a redirect discards everything
    // older, so the next kept response is always the one fetched from the target.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
        if (redirect) begin
            fetch_pc_d = target_aligned;
            rsp_pc_d   = target_aligned;
            discard_d  = outstanding_q - CW'(rsp_fire);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
            if (push)     rsp_pc_d   = rsp_pc_q + ADDR_WIDTH'(4);
            if (rsp_fire && discard_q != '0) discard_d = discard_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (INSTR_WIDTH + ADDR_WIDTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i ({imem_rsp_data, rsp_pc_q}),
        .pop_i       (pop),
        .flush_i     (redirect),
        .head_o      (head),
        .count_o     (q_count)
    );

    assign instr_valid = head_valid;
    assign instr       = head_valid ? head[ADDR_WIDTH +: INSTR_WIDTH] : INSTR_WIDTH'(NOP_INSTR);
    assign instr_pc    = head_valid ? head[ADDR_WIDTH-1:0] : fetch_pc_q;
    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[31:25];

endmodule
